// File: rtl/dsp_sequencer.sv
// dsp_sequencer
// Per-sample instruction sequencer for one dsp_core. A sample_tick starts a
// frame: the stored program is streamed, one word per clock, from a
// double-banked synchronous program RAM to the core's instruction input.
// The sequencer then waits for the core pipeline to drain and pulses
// frame_done. Ticks that arrive while a frame is in flight are dropped and
// flagged as overrun. Host bank swaps are deferred to frame boundaries.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   sample_tick       one-cycle frame start pulse
//   prog_len          instruction count, latched at frame start
//   prog_rd_addr      program RAM read address (registered)
//   prog_bank         program RAM bank select (address MSB, registered)
//   prog_rd_data      program RAM read data, valid one cycle after address
//   instruction       word to dsp_core, NOP (all zeros) when not issuing
//   busy              high while a frame is fetching or draining
//   frame_done        one-cycle pulse when the last writeback completes
//   overrun           sticky dropped-tick flag, cleared by overrun_clr
//   swap_req          request a bank toggle
//   swap_ack          one-cycle pulse when the toggle takes effect
module dsp_sequencer #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int PIPE_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick,
  input  logic [PROG_ADDR_WIDTH:0]   prog_len,
  output logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr,
  output logic                       prog_bank,
  input  logic [INSTR_WIDTH-1:0]     prog_rd_data,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  input  logic                       overrun_clr,
  input  logic                       swap_req,
  output logic                       swap_ack
);

  // The drain counter must be able to hold PIPE_DEPTH itself.
  localparam int CNT_W = $clog2(PIPE_DEPTH + 2);

  localparam logic [PROG_ADDR_WIDTH:0]   LEN_ZERO   = {(PROG_ADDR_WIDTH + 1){1'b0}};
  localparam logic [PROG_ADDR_WIDTH:0]   LEN_ONE    = {{PROG_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PROG_ADDR_WIDTH-1:0] PC_ZERO    = {PROG_ADDR_WIDTH{1'b0}};
  localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE     = {{(PROG_ADDR_WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]           CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]           CNT_ONE    = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]           DRAIN_LAST = CNT_W'(PIPE_DEPTH);
  localparam logic [INSTR_WIDTH-1:0]     NOP        = {INSTR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                     state_r;
  logic [PROG_ADDR_WIDTH-1:0] pc_r;
  logic [PROG_ADDR_WIDTH:0]   len_r;
  logic [CNT_W-1:0]           drain_cnt_r;
  logic                       issue_valid_r;
  logic                       busy_r;
  logic                       frame_done_r;
  logic                       overrun_r;
  logic                       swap_pending_r;
  logic                       swap_ack_r;
  logic                       bank_r;

  logic                       start_s;
  logic                       swap_service_s;
  logic                       last_s;
  logic                       drain_end_s;

  // Frame start, swap service and end-of-phase decodes
  always_comb begin
    // The frame_done cycle of a real frame is IDLE but still busy, so a
    // tick there is an overrun rather than a new frame.
    start_s        = (state_r == ST_IDLE) && !busy_r && sample_tick;
    // A request in the same IDLE cycle is served at once, so a tick plus
    // swap starts the new frame on the new bank.
    swap_service_s = (state_r == ST_IDLE) && (swap_pending_r || swap_req);
    last_s         = ({1'b0, pc_r} == (len_r - LEN_ONE));
    drain_end_s    = (drain_cnt_r == DRAIN_LAST);
  end

  // Frame sequencing: fetch, drain and completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= PC_ZERO;
      len_r         <= LEN_ZERO;
      drain_cnt_r   <= CNT_ZERO;
      issue_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      frame_done_r  <= 1'b0;
      issue_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          pc_r        <= PC_ZERO;
          drain_cnt_r <= CNT_ZERO;
          busy_r      <= 1'b0;
          if (start_s) begin
            len_r <= prog_len;
            if (prog_len == LEN_ZERO) begin
              // Empty program: complete immediately without going busy.
              frame_done_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end else begin
            len_r <= len_r;
          end
        end
        ST_RUN: begin
          // Delayed by one cycle to line up with the RAM read latency.
          issue_valid_r <= 1'b1;
          if (last_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= CNT_ZERO;
          end else begin
            pc_r <= pc_r + PC_ONE;
          end
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            state_r      <= ST_IDLE;
            frame_done_r <= 1'b1;
            pc_r         <= PC_ZERO;
          end else begin
            drain_cnt_r <= drain_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          pc_r        <= PC_ZERO;
          drain_cnt_r <= CNT_ZERO;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag and frame-boundary bank swapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_r      <= 1'b0;
      swap_pending_r <= 1'b0;
      swap_ack_r     <= 1'b0;
      bank_r         <= 1'b0;
    end else begin
      // Set has priority over clear.
      if (sample_tick && busy_r) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end

      swap_ack_r <= swap_service_s;
      if (swap_service_s) begin
        bank_r <= ~bank_r;
        // A fresh request landing on the service of an older one re-arms.
        swap_pending_r <= swap_pending_r & swap_req;
      end else begin
        swap_pending_r <= swap_pending_r | swap_req;
      end
    end
  end

  assign prog_rd_addr = pc_r;
  assign prog_bank    = bank_r;
  assign instruction  = issue_valid_r ? prog_rd_data : NOP;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign overrun      = overrun_r;
  assign swap_ack     = swap_ack_r;

endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer
// Self-checking bench for dsp_sequencer. A synchronous two-bank program RAM
// is modelled in the bench. A frame-level reference model (frame start
// cycle, length and bank) predicts every output each cycle; directed
// scenarios add literal expectations, then a randomized phase follows.
module tb_dsp_sequencer;

  localparam int AW = 10;
  localparam int IW = 26;
  localparam int P  = 4;

  localparam logic [IW-1:0] WA = 26'h0A0A0A1;
  localparam logic [IW-1:0] WB = 26'h0B0B0B2;
  localparam logic [IW-1:0] WC = 26'h0C0C0C3;
  localparam logic [IW-1:0] WD = 26'h2D2D2D4;
  localparam logic [IW-1:0] WE = 26'h2E2E2E5;
  localparam logic [IW-1:0] WF = 26'h2F2F2F6;

  logic          clk;
  logic          reset_n;
  logic          sample_tick;
  logic [AW:0]   prog_len;
  logic [AW-1:0] prog_rd_addr;
  logic          prog_bank;
  logic [IW-1:0] prog_rd_data;
  logic [IW-1:0] instruction;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          overrun_clr;
  logic          swap_req;
  logic          swap_ack;

  dsp_sequencer #(
    .INSTR_WIDTH    (IW),
    .PROG_ADDR_WIDTH(AW),
    .PIPE_DEPTH     (P)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .prog_len    (prog_len),
    .prog_rd_addr(prog_rd_addr),
    .prog_bank   (prog_bank),
    .prog_rd_data(prog_rd_data),
    .instruction (instruction),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program RAM: bank 0 at 0..1023, bank 1 at 1024..2047
  logic [IW-1:0] mem [0:2047];

  // Synchronous program RAM read
  always @(posedge clk) prog_rd_data <= mem[{prog_bank, prog_rd_addr}];

  int n_checks;
  int n_errors;
  int cyc;

  // Frame-level model state
  bit m_act;
  int m_t0;
  int m_len;
  bit m_fbank;
  int m_done_at;
  bit m_bank;
  bit m_pend;
  bit m_ovr;
  bit m_ack;

  // Expectations for the current cycle
  bit            e_busy;
  bit            e_done;
  logic [IW-1:0] e_instr;
  bit            e_addr_chk;
  int            e_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act     = 1'b0;
    m_t0      = 0;
    m_len     = 0;
    m_fbank   = 1'b0;
    m_done_at = -1;
    m_bank    = 1'b0;
    m_pend    = 1'b0;
    m_ovr     = 1'b0;
    m_ack     = 1'b0;
  endtask

  // Outputs are pure functions of where cyc falls in the last frame's windows
  task automatic calc_exp();
    e_busy     = m_act && (cyc >= m_t0 + 1) && (cyc <= m_t0 + 2 + m_len + P);
    e_done     = (cyc == m_done_at);
    e_instr    = '0;
    e_addr_chk = 1'b0;
    e_addr     = 0;
    if (m_act && (cyc >= m_t0 + 2) && (cyc < m_t0 + 2 + m_len))
      e_instr = mem[int'(m_fbank) * 1024 + (cyc - m_t0 - 2)];
    if (m_act && (cyc >= m_t0 + 1) && (cyc <= m_t0 + m_len)) begin
      e_addr_chk = 1'b1;
      e_addr     = cyc - m_t0 - 1;
    end else if (!e_busy) begin
      e_addr_chk = 1'b1;
      e_addr     = 0;
    end
  endtask

  // Apply this cycle's inputs to the model, yielding next cycle's state
  task automatic model_advance(input bit tk, input int ln, input bit sw, input bit cl);
    bit idle;
    bit svc;
    calc_exp();
    // Fetching or draining is everything busy except the completion cycle.
    idle = !(e_busy && !e_done);
    svc  = idle && (m_pend || sw);
    m_ack = svc;
    if (svc) begin
      m_bank = !m_bank;
      m_pend = m_pend && sw;
    end else begin
      m_pend = m_pend || sw;
    end
    if (tk && e_busy) m_ovr = 1'b1;
    else if (cl) m_ovr = 1'b0;
    if (tk && !e_busy) begin
      if (ln == 0) begin
        m_done_at = cyc + 1;
      end else begin
        m_act     = 1'b1;
        m_t0      = cyc;
        m_len     = ln;
        m_fbank   = m_bank;
        m_done_at = cyc + 2 + ln + P;
      end
    end
  endtask

  task automatic compare_all();
    calc_exp();
    chk("instruction", instruction, e_instr);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_done);
    chk("overrun", overrun, m_ovr);
    chk("prog_bank", prog_bank, m_bank);
    chk("swap_ack", swap_ack, m_ack);
    if (e_addr_chk) chk("prog_rd_addr", prog_rd_addr, e_addr);
  endtask

  // One clock: drive inputs, step the model, sample after the edge
  task automatic step(input bit tk, input int ln, input bit sw, input bit cl);
    sample_tick = tk;
    prog_len    = (AW + 1)'(ln);
    swap_req    = sw;
    overrun_clr = cl;
    model_advance(tk, ln, sw, cl);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic apply_reset(input int hold);
    sample_tick = 1'b0;
    swap_req    = 1'b0;
    overrun_clr = 1'b0;
    prog_len    = '0;
    reset_n     = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      cyc++;
      compare_all();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    prog_len    = '0;
    overrun_clr = 1'b0;
    swap_req    = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = IW'($urandom);
    mem[0]    = WA;
    mem[1]    = WB;
    mem[2]    = WC;
    mem[1024] = WD;
    mem[1025] = WE;
    mem[1026] = WF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_busy", busy, 32'd0);
    chk("reset_instr", instruction, 32'd0);
    chk("reset_addr", prog_rd_addr, 32'd0);
    reset_n = 1'b1;

    // Basic L=3 frame from bank 0
    for (int r = 0; r < 12; r++) begin
      step(r == 0, 3, 1'b0, 1'b0);
      case (r + 1)
        1:  chk("t1_busy_c1", busy, 32'd1);
        2:  chk("t1_instr_c2", instruction, 32'(WA));
        3:  chk("t1_instr_c3", instruction, 32'(WB));
        4:  chk("t1_instr_c4", instruction, 32'(WC));
        5:  chk("t1_instr_c5", instruction, 32'd0);
        9:  chk("t1_done_c9", frame_done, 32'd1);
        10: chk("t1_busy_c10", busy, 32'd0);
        default: ;
      endcase
    end

    // Empty program
    for (int r = 0; r < 4; r++) begin
      step(r == 0, 0, 1'b0, 1'b0);
      if (r == 0) begin
        chk("t2_done_c1", frame_done, 32'd1);
        chk("t2_busy_c1", busy, 32'd0);
      end
    end

    // Overrun: dropped ticks, frame_done-cycle tick, set-beats-clear
    for (int r = 0; r < 24; r++) begin
      step((r == 0) || (r == 5) || (r == 9) || (r == 11) || (r == 13), 3, 1'b0,
           (r == 10) || (r == 13) || (r == 22));
      case (r + 1)
        6:  chk("t3_ovr_set", overrun, 32'd1);
        10: chk("t3_no_new_frame", busy, 32'd0);
        11: chk("t3_ovr_clr", overrun, 32'd0);
        14: chk("t3_set_wins", overrun, 32'd1);
        default: ;
      endcase
    end

    // Swap requested mid-frame is deferred to the boundary
    for (int r = 0; r < 21; r++) begin
      step((r == 0) || (r == 11), 3, r == 3, 1'b0);
      case (r + 1)
        9:  chk("t4_bank_c9", prog_bank, 32'd0);
        10: begin
          chk("t4_bank_c10", prog_bank, 32'd1);
          chk("t4_ack_c10", swap_ack, 32'd1);
        end
        13: chk("t4_bank1_word", instruction, 32'(WD));
        default: ;
      endcase
    end

    // Tick and swap in the same IDLE cycle
    apply_reset(2);
    for (int r = 0; r < 12; r++) begin
      step(r == 0, 3, r == 0, 1'b0);
      if (r == 0) chk("t5_bank_c1", prog_bank, 32'd1);
      if (r == 2) chk("t5_word_c3", instruction, 32'(WE));
    end

    // Full-bank frame, then a reset that aborts one mid-way
    apply_reset(1);
    for (int r = 0; r < 1036; r++) begin
      step(r == 0, 1024, 1'b0, 1'b0);
      if (r + 1 == 1024) chk("t6_addr_last", prog_rd_addr, 32'd1023);
      if (r + 1 == 1030) chk("t6_done_full", frame_done, 32'd1);
    end
    for (int r = 0; r < 500; r++) step(r == 0, 1024, 1'b0, 1'b0);
    apply_reset(2);
    chk("t6_rst_busy", busy, 32'd0);
    chk("t6_rst_addr", prog_rd_addr, 32'd0);
    chk("t6_rst_instr", instruction, 32'd0);
    for (int r = 0; r < 1040; r++) begin
      step(r == 0, 3, 1'b0, 1'b0);
      if (r == 1) chk("t6_restart_word", instruction, 32'(WA));
    end

    // Randomized traffic
    for (int r = 0; r < 3000; r++) begin
      if ($urandom_range(0, 699) == 0) begin
        apply_reset(1);
      end else begin
        step($urandom_range(0, 7) == 0,
             ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)),
             $urandom_range(0, 11) == 0,
             $urandom_range(0, 9) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
